// File: rtl/cpu_pkg.sv
// Shared constants and types for the downsampling CPU sequencer, decoder and ALU.
// Holds ALU op codes, opcodes, the sequencer state enum and control bundle.
package cpu_pkg;

  localparam logic [2:0] ALU_ZERO  = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_PAS   = 3'b011;
  localparam logic [2:0] ALU_MUL2  = 3'b100;
  localparam logic [2:0] ALU_DIV2  = 3'b101;
  localparam logic [2:0] ALU_DECAC = 3'b110;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LDAC  = 8'h01;
  localparam logic [7:0] OP_STAC  = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_MVR   = 8'h05;
  localparam logic [7:0] OP_DIV2  = 8'h06;
  localparam logic [7:0] OP_DECAC = 8'h07;
  localparam logic [7:0] OP_MVTR  = 8'h08;
  localparam logic [7:0] OP_JMP   = 8'h09;
  localparam logic [7:0] OP_JMPZ  = 8'h0A;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  // Bit positions inside the one-hot ld vector {DR,AR,TR,R,AC}.
  localparam int LD_AC = 0;
  localparam int LD_R  = 1;
  localparam int LD_TR = 2;
  localparam int LD_AR = 3;
  localparam int LD_DR = 4;

  localparam logic [1:0] BSEL_DR = 2'd0;
  localparam logic [1:0] BSEL_R  = 2'd1;
  localparam logic [1:0] BSEL_TR = 2'd2;
  localparam logic [1:0] BSEL_AR = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_F1,
    S_F2,
    S_F3,
    S_F4,
    S_EX1,
    S_EX2,
    S_EX3,
    S_HALT
  } state_t;

  // Where an execute cycle hands control next.
  typedef enum logic [1:0] {
    NC_FETCH,
    NC_NEXT,
    NC_HALT
  } nxt_cls_t;

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] b_sel;
    logic [4:0] ld;
    logic       dram_rd;
    logic       dram_wr;
  } ctrl_t;

  function automatic logic is_two_byte(input logic [7:0] op);
    return (op == OP_JMP) || (op == OP_JMPZ);
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational control decode: (state, ir, z_flag) -> datapath strobes and next-state class.
// Zero latency; no flow control, outputs are idle outside execute states.
module cpu_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [7:0] ir,
  input  logic       z_flag,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       pc_jump,
  output nxt_cls_t   nxt_cls
);

  logic in_ex;

  assign in_ex = (state == S_EX1) || (state == S_EX2) || (state == S_EX3);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    pc_jump = 1'b0;
    nxt_cls = NC_FETCH;
    if (in_ex) begin
      case (ir)
        OP_NOP: ;
        OP_LDAC: begin
          case (state)
            S_EX1: begin
              ctrl.dram_rd = 1'b1;
              nxt_cls      = NC_NEXT;
            end
            S_EX2: begin
              ctrl.ld[LD_DR] = 1'b1;
              nxt_cls        = NC_NEXT;
            end
            default: begin
              ctrl.alu       = ALU_PAS;
              ctrl.b_sel     = BSEL_DR;
              ctrl.ld[LD_AC] = 1'b1;
            end
          endcase
        end
        OP_STAC: begin
          if (state == S_EX1) begin
            ctrl.alu       = ALU_ZERO;
            ctrl.ld[LD_DR] = 1'b1;
            nxt_cls        = NC_NEXT;
          end else begin
            ctrl.dram_wr = 1'b1;
          end
        end
        OP_ADD: begin
          ctrl.alu       = ALU_ADD;
          ctrl.b_sel     = BSEL_R;
          ctrl.ld[LD_AC] = 1'b1;
        end
        OP_SUB: begin
          ctrl.alu       = ALU_SUB;
          ctrl.b_sel     = BSEL_R;
          ctrl.ld[LD_AC] = 1'b1;
        end
        OP_MVR: begin
          ctrl.alu      = ALU_ZERO;
          ctrl.ld[LD_R] = 1'b1;
        end
        OP_DIV2: begin
          ctrl.alu       = ALU_DIV2;
          ctrl.b_sel     = BSEL_R;
          ctrl.ld[LD_AC] = 1'b1;
        end
        OP_DECAC: begin
          ctrl.alu       = ALU_DECAC;
          ctrl.ld[LD_AC] = 1'b1;
        end
        OP_MVTR: begin
          ctrl.alu       = ALU_ZERO;
          ctrl.ld[LD_TR] = 1'b1;
        end
        OP_JMP:  pc_jump = 1'b1;
        // z_flag here is the value registered before EX1, so a SUB just before is visible.
        OP_JMPZ: pc_jump = z_flag;
        OP_HALT: nxt_cls = NC_HALT;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetches opcodes, steps the datapath, registers the ALU zero flag.
// 3-5 cycles per instruction; no backpressure, start is only honoured in IDLE/HALT.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned    AW       = 8,
  parameter logic [AW-1:0]  START_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    instr,
  input  logic          z,
  output logic [AW-1:0] iram_addr,
  output logic [2:0]    alu_control,
  output logic [1:0]    b_sel,
  output logic [4:0]    ld,
  output logic          dram_rd,
  output logic          dram_wr,
  output logic          done,
  output logic          illegal
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] pc;
  logic [7:0]    ir;
  logic [AW-1:0] opr;
  logic          z_flag;

  ctrl_t         dec_ctrl;
  logic          dec_illegal;
  logic          dec_pc_jump;
  nxt_cls_t      dec_nxt_cls;

  cpu_decode u_decode (
    .state   (state),
    .ir      (ir),
    .z_flag  (z_flag),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .pc_jump (dec_pc_jump),
    .nxt_cls (dec_nxt_cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_F1;
      S_F1:           state_nxt = S_F2;
      // Opcode length is judged from the RAM data as it lands in ir.
      S_F2:           state_nxt = is_two_byte(instr) ? S_F3 : S_EX1;
      S_F3:           state_nxt = S_F4;
      S_F4:           state_nxt = S_EX1;
      S_EX1, S_EX2, S_EX3: begin
        case (dec_nxt_cls)
          NC_HALT: state_nxt = S_HALT;
          NC_NEXT: state_nxt = (state == S_EX1) ? S_EX2 :
                               (state == S_EX2) ? S_EX3 : S_F1;
          default: state_nxt = S_F1;
        endcase
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    iram_addr   = pc;
    alu_control = dec_ctrl.alu;
    b_sel       = dec_ctrl.b_sel;
    ld          = dec_ctrl.ld;
    dram_rd     = dec_ctrl.dram_rd;
    dram_wr     = dec_ctrl.dram_wr;
    done        = (state == S_HALT);
    illegal     = dec_illegal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= START_PC;
      ir     <= '0;
      opr    <= '0;
      z_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) pc <= START_PC;
        S_F2: begin
          ir <= instr;
          pc <= pc + AW'(1);
        end
        S_F4: begin
          opr <= AW'(instr);
          pc  <= pc + AW'(1);
        end
        S_EX1: if (dec_pc_jump) pc <= opr;
        default: ;
      endcase
      // Flag follows only ops whose result the datapath can test (SUB and PAS).
      if (dec_ctrl.alu == ALU_SUB || dec_ctrl.alu == ALU_PAS) begin
        z_flag <= z;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed programs plus random programs against an instruction-level model.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] instr;
  logic       z;
  logic [7:0] iram_addr;
  logic [2:0] alu_control;
  logic [1:0] b_sel;
  logic [4:0] ld;
  logic       dram_rd;
  logic       dram_wr;
  logic       done;
  logic       illegal;

  cpu_sequencer #(.AW(8), .START_PC(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instr       (instr),
    .z           (z),
    .iram_addr   (iram_addr),
    .alu_control (alu_control),
    .b_sel       (b_sel),
    .ld          (ld),
    .dram_rd     (dram_rd),
    .dram_wr     (dram_wr),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  bit [7:0] mem [256];
  always @(posedge clk) instr <= mem[iram_addr];

  int       total = 0;
  int       bad   = 0;
  logic [7:0] mpc;
  logic [7:0] opr;
  bit       mz;
  bit       halted;
  bit       force_start;
  bit       noise;
  int       z_force;

  task automatic chk(input string tag, input logic [21:0] exp);
    logic [21:0] obs;
    obs = {iram_addr, alu_control, b_sel, ld, dram_rd, dram_wr, done, illegal};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag, input logic [7:0] exp);
    total++;
    assert (iram_addr === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, iram_addr, exp);
    end
  endtask

  function automatic bit ns();
    return force_start || (noise && ($urandom % 2 == 1));
  endfunction

  // One clock cycle: check outputs, drive z/start for this cycle, advance to the next negedge.
  task automatic cyc(input string tag, input logic [2:0] alu, input logic [1:0] bs,
                     input logic [4:0] ldv, input bit rd, input bit wr, input bit dn,
                     input bit il, input bit st);
    chk(tag, {mpc, alu, bs, ldv, rd, wr, dn, il});
    z = (z_force < 0) ? 1'($urandom % 2) : (z_force != 0);
    if (alu == 3'b010 || alu == 3'b011) mz = z;
    start = st;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic q(input string tag, input bit st);
    cyc(tag, 3'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, st);
  endtask

  task automatic run_instr();
    logic [7:0] op;
    op = mem[mpc];
    q("f1", ns());
    q("f2", ns());
    mpc++;
    if (op == 8'h09 || op == 8'h0A) begin
      q("f3", ns());
      opr = mem[mpc];
      q("f4", ns());
      mpc++;
    end
    case (op)
      8'h00: q("nop", ns());
      8'h01: begin
        cyc("ldac_rd", 3'd0, 2'd0, 5'b00000, 1, 0, 0, 0, ns());
        cyc("ldac_dr", 3'd0, 2'd0, 5'b10000, 0, 0, 0, 0, ns());
        cyc("ldac_ac", 3'd3, 2'd0, 5'b00001, 0, 0, 0, 0, ns());
      end
      8'h02: begin
        cyc("stac_dr", 3'd0, 2'd0, 5'b10000, 0, 0, 0, 0, ns());
        cyc("stac_wr", 3'd0, 2'd0, 5'b00000, 0, 1, 0, 0, ns());
      end
      8'h03: cyc("add",   3'd1, 2'd1, 5'b00001, 0, 0, 0, 0, ns());
      8'h04: cyc("sub",   3'd2, 2'd1, 5'b00001, 0, 0, 0, 0, ns());
      8'h05: cyc("mvr",   3'd0, 2'd0, 5'b00010, 0, 0, 0, 0, ns());
      8'h06: cyc("div2",  3'd5, 2'd1, 5'b00001, 0, 0, 0, 0, ns());
      8'h07: cyc("decac", 3'd6, 2'd0, 5'b00001, 0, 0, 0, 0, ns());
      8'h08: cyc("mvtr",  3'd0, 2'd0, 5'b00100, 0, 0, 0, 0, ns());
      8'h09: begin
        q("jmp", ns());
        mpc = opr;
      end
      8'h0A: begin
        q("jmpz", ns());
        if (mz) mpc = opr;
      end
      8'hFF: begin
        q("halt_ex", ns());
        halted = 1'b1;
      end
      default: cyc("illegal", 3'd0, 2'd0, 5'b00000, 0, 0, 0, 1, ns());
    endcase
  endtask

  task automatic halt_restart();
    repeat (3) cyc("halt_hold", 3'd0, 2'd0, 5'd0, 0, 0, 1, 0, 0);
    cyc("halt_start", 3'd0, 2'd0, 5'd0, 0, 0, 1, 0, 1);
    mpc    = 8'h00;
    halted = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    #1;
    mpc    = 8'h00;
    mz     = 1'b0;
    halted = 1'b0;
    chk("reset_now", {8'h00, 14'h0});
    @(negedge clk);
    chk("reset_hold", {8'h00, 14'h0});
    reset = 1'b0;
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 8'h00;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; z = 1'b0;
    z_force = -1; noise = 1'b0; force_start = 1'b0;
    mpc = 8'h00; opr = 8'h00; mz = 1'b0; halted = 1'b0;
    #2;

    // ADD then HALT; start held high throughout must be ignored, done held after.
    clear_mem();
    mem[0] = 8'h03; mem[1] = 8'hFF;
    do_reset();
    repeat (3) q("idle", 0);
    q("idle_start", 1);
    force_start = 1'b1;
    run_instr();
    run_instr();
    force_start = 1'b0;
    halt_restart();
    run_instr();
    run_instr();

    // SUB with z=1 then JMPZ taken; again with z=0 not taken.
    clear_mem();
    mem[0] = 8'h04; mem[1] = 8'h0A; mem[2] = 8'h10; mem[3] = 8'hFF; mem[8'h10] = 8'hFF;
    do_reset();
    q("idle_start", 1);
    z_force = 1;
    run_instr();
    run_instr();
    chk_addr("jmpz_taken", 8'h10);
    run_instr();
    halt_restart();
    z_force = 0;
    run_instr();
    run_instr();
    chk_addr("jmpz_not_taken", 8'h03);
    run_instr();
    halt_restart();
    z_force = -1;

    // Undefined opcode behaves as a NOP with one illegal pulse.
    clear_mem();
    mem[0] = 8'h3C; mem[1] = 8'hFF;
    do_reset();
    q("idle_start", 1);
    run_instr();
    run_instr();
    halt_restart();

    // PC wrap: jump to 0xFF, NOP there, next fetch from 0x00.
    clear_mem();
    mem[0] = 8'h09; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    do_reset();
    q("idle_start", 1);
    run_instr();
    run_instr();
    chk_addr("pc_wrap", 8'h00);
    run_instr();

    // LDAC in full, then reset while the second LDAC is asserting dram_rd.
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h01;
    do_reset();
    q("idle_start", 1);
    run_instr();
    q("f1", 0);
    q("f2", 0);
    mpc++;
    chk("ldac_ex1_pre_reset", {mpc, 3'd0, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    do_reset();
    repeat (4) q("idle_no_start", 0);

    // Random programs with random z and stray start pulses.
    noise = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) begin
        int unsigned k;
        k = $urandom % 16;
        if (k <= 10)      mem[i] = 8'(k);
        else if (k == 11) mem[i] = 8'hFF;
        else              mem[i] = 8'($urandom % 256);
      end
      do_reset();
      q("idle_start", 1);
      for (int n = 0; n < 50; n++) begin
        run_instr();
        if (halted) halt_restart();
      end
    end
    noise = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
